// File: rtl/cmd_decoder.sv
// cmd_decoder: turns a UART byte stream into short (1-byte) and long (5-byte)
// commands, with a per-byte timeout and framing-error abort for long commands.
//
// Ports:
//   clock        system clock, rising edge
//   ext_reset    asynchronous active-high reset
//   rx_data      received byte, valid while rx_valid=1
//   rx_valid     one-cycle strobe per received byte
//   rx_error     framing/parity error, qualified by rx_valid
//   opcode       opcode of the last completed command
//   command      32-bit argument of the last completed command (0 if short)
//   cmd_recv_rx  one-cycle pulse: opcode/command just updated
//   long_cmd     last completed command was a 5-byte command
//   abort_err    one-cycle pulse: partial long command discarded
module cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        ext_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  opcode,
    output logic [31:0] command,
    output logic        cmd_recv_rx,
    output logic        long_cmd,
    output logic        abort_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ARGS,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    pend_q, pend_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   arg_q, arg_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [7:0]    op_d;
    logic [31:0]   cmd_d;
    logic          long_d;
    logic          abort_d;
    logic          accept;
    logic          bad;

    assign accept = rx_valid & ~rx_error;
    assign bad    = rx_valid & rx_error;

    // Saturating idle counter; it cannot wrap back into a legal range.
    assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

    // DONE lasts exactly one cycle, so the pulse is simply the state.
    assign cmd_recv_rx = (state == DONE);

    always_comb begin
        state_nx = state;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        arg_d    = arg_q;
        tmo_d    = tmo_q;
        op_d     = opcode;
        cmd_d    = command;
        long_d   = long_cmd;
        abort_d  = 1'b0;
        case (state)
            // DONE behaves like IDLE so back-to-back bytes are not lost.
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept) begin
                    if (!rx_data[7]) begin
                        op_d     = rx_data;
                        cmd_d    = '0;
                        long_d   = 1'b0;
                        state_nx = DONE;
                    end else begin
                        pend_d   = rx_data;
                        cnt_d    = '0;
                        arg_d    = '0;
                        tmo_d    = '0;
                        state_nx = ARGS;
                    end
                end
            end
            ARGS: begin
                unique case (1'b1)
                    bad: begin
                        abort_d  = 1'b1;
                        state_nx = IDLE;
                    end
                    accept: begin
                        arg_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        cnt_d = cnt_q + 2'd1;
                        tmo_d = '0;
                        if (cnt_q == 2'd3) begin
                            op_d     = pend_q;
                            cmd_d    = {rx_data, arg_q[23:0]};
                            long_d   = 1'b1;
                            state_nx = DONE;
                        end
                    end
                    default: begin
                        tmo_d = tmo_inc;
                        if (tmo_inc == TMO_MAX) begin
                            abort_d  = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                endcase
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge ext_reset) begin
        if (ext_reset) begin
            state     <= IDLE;
            pend_q    <= '0;
            cnt_q     <= '0;
            arg_q     <= '0;
            tmo_q     <= '0;
            opcode    <= '0;
            command   <= '0;
            long_cmd  <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            state     <= state_nx;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            arg_q     <= arg_d;
            tmo_q     <= tmo_d;
            opcode    <= op_d;
            command   <= cmd_d;
            long_cmd  <= long_d;
            abort_err <= abort_d;
        end
    end

endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed and random byte streams for cmd_decoder,
// checked against a queue-based command model.
module tb_cmd_decoder;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        ext_reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_error = 1'b0;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        long_cmd;
    logic        abort_err;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit         m_in_long = 0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_args[$];
    int         m_idle = 0;
    logic [7:0] m_op = '0;
    logic [31:0] m_cmd = '0;
    bit         m_long = 0;
    bit         e_recv = 0;
    bit         e_abort = 0;

    cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock),
        .ext_reset(ext_reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .opcode(opcode),
        .command(command),
        .cmd_recv_rx(cmd_recv_rx),
        .long_cmd(long_cmd),
        .abort_err(abort_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_long = 0;
        m_pend = '0;
        m_args.delete();
        m_idle = 0;
        m_op = '0;
        m_cmd = '0;
        m_long = 0;
        e_recv = 0;
        e_abort = 0;
    endtask

    task automatic model_edge(input bit v, input bit e, input logic [7:0] d);
        e_recv = 0;
        e_abort = 0;
        if (!m_in_long) begin
            if (v && !e) begin
                if (!d[7]) begin
                    m_op = d;
                    m_cmd = '0;
                    m_long = 0;
                    e_recv = 1;
                end else begin
                    m_in_long = 1;
                    m_pend = d;
                    m_args.delete();
                    m_idle = 0;
                end
            end
        end else if (v && e) begin
            e_abort = 1;
            m_in_long = 0;
        end else if (v) begin
            m_args.push_back(d);
            m_idle = 0;
            if (m_args.size() == 4) begin
                m_op = m_pend;
                m_cmd = {m_args[3], m_args[2], m_args[1], m_args[0]};
                m_long = 1;
                e_recv = 1;
                m_in_long = 0;
            end
        end else begin
            m_idle++;
            if (m_idle >= TMO) begin
                e_abort = 1;
                m_in_long = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("cmd_recv_rx", 32'(cmd_recv_rx), 32'(e_recv));
        chk("abort_err", 32'(abort_err), 32'(e_abort));
        chk("opcode", 32'(opcode), 32'(m_op));
        chk("command", command, m_cmd);
        chk("long_cmd", 32'(long_cmd), 32'(m_long));
    endtask

    // Entered shortly after a rising edge; leaves 1 time unit after the next.
    task automatic step(input bit v, input bit e, input logic [7:0] d);
        rx_valid = v;
        rx_error = e;
        rx_data = d;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        model_edge(v, e, d);
        check_outputs();
    endtask

    initial begin
        int n;
        int pulses;
        bit v;
        bit e;

        model_reset();
        #12;
        check_outputs();
        @(posedge clock);
        #3 ext_reset = 1'b0;

        // short command
        step(1, 0, 8'h02);
        chk("short_recv", 32'(cmd_recv_rx), 32'd1);
        chk("short_op", 32'(opcode), 32'h02);
        chk("short_cmd", command, 32'h0);
        chk("short_long", 32'(long_cmd), 32'd0);
        step(0, 0, 8'h00);

        // back-to-back 0x00 short commands
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'h00);
            if (cmd_recv_rx) pulses++;
            chk("zero_op", 32'(opcode), 32'h00);
        end
        chk("zero_pulses", 32'(pulses), 32'd5);
        step(0, 0, 8'h00);

        // long command
        step(1, 0, 8'hC0);
        step(1, 0, 8'h78);
        step(1, 0, 8'h56);
        step(1, 0, 8'h34);
        step(1, 0, 8'h12);
        chk("long_recv", 32'(cmd_recv_rx), 32'd1);
        chk("long_op", 32'(opcode), 32'hC0);
        chk("long_cmd_word", command, 32'h12345678);
        chk("long_flag", 32'(long_cmd), 32'd1);
        step(0, 0, 8'h00);

        // timeout after one argument byte
        step(1, 0, 8'h80);
        step(1, 0, 8'hAA);
        n = 0;
        for (int i = 0; i < 4 * TMO; i++) begin
            step(0, 0, 8'h00);
            n++;
            if (abort_err) break;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_abort", 32'(abort_err), 32'd1);
        chk("tmo_op_held", 32'(opcode), 32'hC0);
        chk("tmo_cmd_held", command, 32'h12345678);
        chk("tmo_long_held", 32'(long_cmd), 32'd1);
        step(1, 0, 8'h04);
        chk("after_tmo_op", 32'(opcode), 32'h04);

        // rx_error abort, then a clean long command
        step(1, 0, 8'h81);
        step(1, 0, 8'h01);
        step(1, 1, 8'h55);
        chk("err_abort", 32'(abort_err), 32'd1);
        step(1, 0, 8'h81);
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 0, 8'h04);
        chk("err_then_cmd", command, 32'h04030201);
        chk("err_then_op", 32'(opcode), 32'h81);

        // asynchronous reset mid-command
        step(1, 0, 8'h82);
        step(1, 0, 8'h11);
        #3 ext_reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #3 ext_reset = 1'b0;
        step(1, 0, 8'h11);
        chk("post_reset_op", 32'(opcode), 32'h11);
        chk("post_reset_long", 32'(long_cmd), 32'd0);
        chk("post_reset_recv", 32'(cmd_recv_rx), 32'd1);

        // random traffic, including idle gaps long enough to time out
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                n = $urandom_range(TMO - 4, TMO + 4);
                for (int k = 0; k < n; k++)
                    step(0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else begin
                v = ($urandom_range(0, 99) < 60);
                e = v ? ($urandom_range(0, 19) == 0)
                      : 1'($urandom_range(0, 1));
                step(v, e, 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
